// File: rtl/calc_op_driver.sv
// calc_op_driver: issues one command at a time to the calculator and returns its result after LAT cycles; CALC_OP_DRIVER_STICKY_OF_EN adds a sticky overflow flag.
module calc_op_driver #(
   parameter int LAT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   input  logic [2:0] cmd_op,
   output logic [7:0] calc_a,
   output logic [7:0] calc_b,
   output logic [2:0] calc_op,
   output logic       calc_load,
   input  logic [7:0] calc_y,
   input  logic       calc_c,
   input  logic       calc_of,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_y,
   output logic       rsp_c,
   output logic       rsp_of,
   output logic [2:0] rsp_op,
   output logic       busy
`ifdef CALC_OP_DRIVER_STICKY_OF_EN
  ,input  logic       sticky_clr,
   output logic       sticky_of
`endif
);
   typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;
   state_t state, state_n;
   logic [3:0] cnt;
   logic cap;
   always_ff @(posedge clk) state <= rst ? IDLE : state_n;
   always_comb begin
      cmd_ready = state == IDLE;
      calc_load = state == LOAD;
      rsp_valid = state == RESP;
      busy = state != IDLE;
      cap = state == WAIT && cnt == 4'd1;
      state_n = state == IDLE ? (cmd_valid ? LOAD : IDLE) :
                state == LOAD ? WAIT :
                state == WAIT ? (cap ? RESP : WAIT) :
                (rsp_ready ? IDLE : RESP);
   end
   // calc_op only changes in IDLE, so it doubles as the opcode echoed on rsp_op
   always_ff @(posedge clk) begin
      if (rst) begin
         calc_a <= '0;
         calc_b <= '0;
         calc_op <= '0;
         cnt <= '0;
         rsp_y <= '0;
         rsp_c <= 1'b0;
         rsp_of <= 1'b0;
         rsp_op <= '0;
      end else begin
         if (cmd_valid && cmd_ready) begin
            calc_a <= cmd_a;
            calc_b <= cmd_b;
            calc_op <= cmd_op;
         end
         if (calc_load) cnt <= 4'(LAT);
         else if (state == WAIT) cnt <= cnt - 4'd1;
         if (cap) begin
            rsp_y <= calc_y;
            rsp_c <= calc_c;
            rsp_of <= calc_of;
            rsp_op <= calc_op;
         end
      end
   end
`ifdef CALC_OP_DRIVER_STICKY_OF_EN
   always_ff @(posedge clk) sticky_of <= rst ? 1'b0 : (cap && calc_of) ? 1'b1 : sticky_clr ? 1'b0 : sticky_of;
`endif
endmodule

// File: tb/tb_calc_op_driver.sv
// tb_calc_op_driver: directed checks of calc_op_driver at LAT=2 and LAT=3 against a small calculator model.
module tb_calc_op_driver;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic [7:0] a, b;
   logic [2:0] op;
   logic rsp_ready, sticky_clr, v2, v3;
   logic rdy2, ld2, rv2, rc2, rof2, busy2, c2i, of2i, sof2;
   logic rdy3, ld3, rv3, rc3, rof3, busy3, c3i, of3i, sof3;
   logic [7:0] ca2, cb2, ry2, y2i, ca3, cb3, ry3, y3i;
   logic [2:0] cop2, rop2, cop3, rop3;
   int n_cmp = 0, n_bad = 0;

   function automatic logic [9:0] calc(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
      logic [8:0] s;
      logic f;
      s = o == 3'd0 ? {1'b0, x} + {1'b0, y} : o == 3'd1 ? {1'b0, x} - {1'b0, y} : {1'b0, x ^ y};
      f = o == 3'd0 ? (x[7] == y[7] && s[7] != x[7]) : o == 3'd1 ? (x[7] != y[7] && s[7] != x[7]) : 1'b0;
      return {f, s};
   endfunction
   assign {of2i, c2i, y2i} = calc(ca2, cb2, cop2);
   assign {of3i, c3i, y3i} = calc(ca3, cb3, cop3);

   calc_op_driver #(.LAT(2)) u2 (
      .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_ready(rdy2), .cmd_a(a), .cmd_b(b), .cmd_op(op),
      .calc_a(ca2), .calc_b(cb2), .calc_op(cop2), .calc_load(ld2), .calc_y(y2i), .calc_c(c2i), .calc_of(of2i),
      .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_y(ry2), .rsp_c(rc2), .rsp_of(rof2), .rsp_op(rop2), .busy(busy2)
`ifdef CALC_OP_DRIVER_STICKY_OF_EN
     ,.sticky_clr(sticky_clr), .sticky_of(sof2)
`endif
   );
   calc_op_driver #(.LAT(3)) u3 (
      .clk(clk), .rst(rst), .cmd_valid(v3), .cmd_ready(rdy3), .cmd_a(a), .cmd_b(b), .cmd_op(op),
      .calc_a(ca3), .calc_b(cb3), .calc_op(cop3), .calc_load(ld3), .calc_y(y3i), .calc_c(c3i), .calc_of(of3i),
      .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_y(ry3), .rsp_c(rc3), .rsp_of(rof3), .rsp_op(rop3), .busy(busy3)
`ifdef CALC_OP_DRIVER_STICKY_OF_EN
     ,.sticky_clr(sticky_clr), .sticky_of(sof3)
`endif
   );

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_basic;
      rsp_ready = 1'b1; a = 8'h12; b = 8'h34; op = 3'd0; v2 = 1'b1;
      n_cmp++; if (rdy2 !== 1'b1) begin n_bad++; $display("FAIL basic_rdy_c0 got=%b exp=1", rdy2); end
      tick; v2 = 1'b0;
      n_cmp++; if ({ld2, rdy2, busy2, rv2} !== 4'b1010) begin n_bad++; $display("FAIL basic_ctl_c1 got=%b exp=1010", {ld2, rdy2, busy2, rv2}); end
      n_cmp++; if ({ca2, cb2, cop2} !== {8'h12, 8'h34, 3'd0}) begin n_bad++; $display("FAIL basic_calc_ops got=%h/%h/%h exp=12/34/0", ca2, cb2, cop2); end
      for (int c = 2; c <= 3; c++) begin
         tick;
         n_cmp++; if ({ld2, rdy2, busy2, rv2} !== 4'b0010) begin n_bad++; $display("FAIL basic_ctl_c%0d got=%b exp=0010", c, {ld2, rdy2, busy2, rv2}); end
      end
      tick;
      n_cmp++; if ({ld2, rdy2, busy2, rv2} !== 4'b0011) begin n_bad++; $display("FAIL basic_ctl_c4 got=%b exp=0011", {ld2, rdy2, busy2, rv2}); end
      n_cmp++; if ({ry2, rc2, rof2, rop2} !== {8'h46, 1'b0, 1'b0, 3'd0}) begin n_bad++; $display("FAIL basic_rsp got=%h/%b/%b/%h exp=46/0/0/0", ry2, rc2, rof2, rop2); end
      tick;
      n_cmp++; if ({ld2, rdy2, busy2, rv2} !== 4'b0100) begin n_bad++; $display("FAIL basic_ctl_c5 got=%b exp=0100", {ld2, rdy2, busy2, rv2}); end
      n_cmp++; if (ry2 !== 8'h46) begin n_bad++; $display("FAIL basic_rsp_kept got=%h exp=46", ry2); end
   endtask

   task automatic test_stall;
      rsp_ready = 1'b0; a = 8'h80; b = 8'h80; op = 3'd0; v2 = 1'b1;
      tick; a = 8'h05; b = 8'h07; op = 3'd1;
      n_cmp++; if ({ld2, ca2, cb2} !== {1'b1, 8'h80, 8'h80}) begin n_bad++; $display("FAIL stall_load got=%b/%h/%h exp=1/80/80", ld2, ca2, cb2); end
      tick; tick;
      n_cmp++; if ({ld2, ca2, rdy2} !== {1'b0, 8'h80, 1'b0}) begin n_bad++; $display("FAIL stall_hold got=%b/%h/%b exp=0/80/0", ld2, ca2, rdy2); end
      for (int i = 0; i < 5; i++) begin
         tick;
         n_cmp++; if ({rv2, rdy2, ld2} !== 3'b100) begin n_bad++; $display("FAIL stall_ctl_%0d got=%b exp=100", i, {rv2, rdy2, ld2}); end
         n_cmp++; if ({ry2, rc2, rof2, rop2} !== {8'h00, 1'b1, 1'b1, 3'd0}) begin n_bad++; $display("FAIL stall_rsp_%0d got=%h/%b/%b/%h exp=00/1/1/0", i, ry2, rc2, rof2, rop2); end
      end
      rsp_ready = 1'b1;
      tick;
      n_cmp++; if ({rdy2, rv2, ry2} !== {1'b1, 1'b0, 8'h00}) begin n_bad++; $display("FAIL stall_release got=%b/%b/%h exp=1/0/00", rdy2, rv2, ry2); end
      tick; v2 = 1'b0;
      n_cmp++; if ({ld2, ca2, cb2, cop2} !== {1'b1, 8'h05, 8'h07, 3'd1}) begin n_bad++; $display("FAIL stall_held_cmd got=%b/%h/%h/%h exp=1/05/07/1", ld2, ca2, cb2, cop2); end
      tick; tick; tick;
      n_cmp++; if ({rv2, ry2, rc2, rof2, rop2} !== {1'b1, 8'hFE, 1'b1, 1'b0, 3'd1}) begin n_bad++; $display("FAIL stall_second_rsp got=%b/%h/%b/%b/%h exp=1/fe/1/0/1", rv2, ry2, rc2, rof2, rop2); end
      tick;
   endtask

   task automatic test_reset;
      rsp_ready = 1'b0; a = 8'h55; b = 8'h11; op = 3'd1; v2 = 1'b1;
      tick; v2 = 1'b0;
      tick; tick; tick;
      n_cmp++; if ({rv2, ry2} !== {1'b1, 8'h44}) begin n_bad++; $display("FAIL reset_pre_rsp got=%b/%h exp=1/44", rv2, ry2); end
      rst = 1'b1;
      tick;
      n_cmp++; if ({ca2, cb2, cop2, ld2, rv2, ry2, rc2, rof2, rop2, busy2} !== 35'd0) begin n_bad++; $display("FAIL reset_u2_zero got=%h exp=0", {ca2, cb2, cop2, ld2, rv2, ry2, rc2, rof2, rop2, busy2}); end
      n_cmp++; if ({ld3, rv3, busy3} !== 3'd0) begin n_bad++; $display("FAIL reset_u3_zero got=%b exp=000", {ld3, rv3, busy3}); end
      tick; rst = 1'b0;
      n_cmp++; if ({rdy2, rv2} !== 2'b10) begin n_bad++; $display("FAIL reset_rdy_after got=%b exp=10", {rdy2, rv2}); end
      tick;
      n_cmp++; if ({rdy2, rv2, busy2} !== 3'b100) begin n_bad++; $display("FAIL reset_idle got=%b exp=100", {rdy2, rv2, busy2}); end
   endtask

   task automatic test_reset_wait;
      rsp_ready = 1'b1; a = 8'h10; b = 8'h20; op = 3'd0; v2 = 1'b1;
      tick; v2 = 1'b0;
      tick; rst = 1'b1;
      tick; rst = 1'b0;
      n_cmp++; if ({rv2, busy2} !== 2'b00) begin n_bad++; $display("FAIL rstwait_abort got=%b exp=00", {rv2, busy2}); end
      for (int i = 0; i < 5; i++) begin
         tick;
         n_cmp++; if (rv2 !== 1'b0) begin n_bad++; $display("FAIL rstwait_no_rsp_%0d got=%b exp=0", i, rv2); end
      end
      a = 8'h03; b = 8'h04; op = 3'd2; v2 = 1'b1;
      tick; v2 = 1'b0;
      tick; tick; tick;
      n_cmp++; if ({rv2, ry2, rc2, rof2, rop2} !== {1'b1, 8'h07, 1'b0, 1'b0, 3'd2}) begin n_bad++; $display("FAIL rstwait_next got=%b/%h/%b/%b/%h exp=1/07/0/0/2", rv2, ry2, rc2, rof2, rop2); end
      tick;
   endtask

   task automatic test_back_to_back;
      logic [7:0] xa [3] = '{8'h01, 8'h10, 8'hF0};
      logic [7:0] xb [3] = '{8'h02, 8'h01, 8'h0F};
      logic [2:0] xo [3] = '{3'd0, 3'd1, 3'd2};
      logic [7:0] ey [3] = '{8'h03, 8'h0F, 8'hFF};
      rsp_ready = 1'b1; v3 = 1'b1;
      for (int k = 0; k < 18; k++) begin
         if (k % 6 == 0) begin a = xa[k / 6]; b = xb[k / 6]; op = xo[k / 6]; end
         if (k == 13) v3 = 1'b0;
         n_cmp++; if ({rdy3, ld3, rv3} !== {k % 6 == 0, k % 6 == 1, k % 6 == 5}) begin n_bad++; $display("FAIL b2b_ctl_c%0d got=%b exp=%b", k, {rdy3, ld3, rv3}, {k % 6 == 0, k % 6 == 1, k % 6 == 5}); end
         if (k % 6 == 5) begin
            n_cmp++; if ({ry3, rop3} !== {ey[k / 6], xo[k / 6]}) begin n_bad++; $display("FAIL b2b_rsp_%0d got=%h/%h exp=%h/%h", k / 6, ry3, rop3, ey[k / 6], xo[k / 6]); end
         end
         tick;
      end
   endtask

`ifdef CALC_OP_DRIVER_STICKY_OF_EN
   task automatic test_sticky;
      rsp_ready = 1'b1; sticky_clr = 1'b0;
      n_cmp++; if (sof2 !== 1'b0) begin n_bad++; $display("FAIL sticky_init got=%b exp=0", sof2); end
      a = 8'h7F; b = 8'h01; op = 3'd0; v2 = 1'b1;
      tick; v2 = 1'b0;
      tick; tick; tick;
      n_cmp++; if ({rv2, ry2, rof2, sof2} !== {1'b1, 8'h80, 1'b1, 1'b1}) begin n_bad++; $display("FAIL sticky_set got=%b/%h/%b/%b exp=1/80/1/1", rv2, ry2, rof2, sof2); end
      tick;
      a = 8'h01; b = 8'h01; v2 = 1'b1;
      tick; v2 = 1'b0;
      tick; tick; tick;
      n_cmp++; if ({rv2, rof2, sof2} !== 3'b101) begin n_bad++; $display("FAIL sticky_hold got=%b exp=101", {rv2, rof2, sof2}); end
      tick; sticky_clr = 1'b1;
      tick; sticky_clr = 1'b0;
      n_cmp++; if (sof2 !== 1'b0) begin n_bad++; $display("FAIL sticky_clr got=%b exp=0", sof2); end
   endtask
`endif

   initial begin
      v2 = 1'b0; v3 = 1'b0; a = '0; b = '0; op = '0; rsp_ready = 1'b0; sticky_clr = 1'b0;
      @(negedge clk);
      tick;
      rst = 1'b0;
      test_basic;
      test_stall;
      test_reset;
      test_reset_wait;
      test_back_to_back;
`ifdef CALC_OP_DRIVER_STICKY_OF_EN
      test_sticky;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/calc_op_driver.md
Name: calc_op_driver

Overview:
- Issuing end of the calculator operand interface. Accepts one command (A, B, Op) per valid/ready handshake and drives the calculator's operand registers and load enable.
- Waits a fixed, parameterised number of cycles for the result, then captures Y/C/Of.
- Presents the captured result on a valid/ready response port.
- Sits between the control/sequencing logic and the calculator datapath, and serialises all accesses to the calculator.

Parameters:
- LAT, 2: cycles from the calc_load cycle to result sampling. Legal range 1..15; counter is 4 bits wide.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  driver can accept a command
- cmd_a  input  8  operand A
- cmd_b  input  8  operand B
- cmd_op  input  3  operation code; passed through, not interpreted
- calc_a  output  8  registered operand A to calculator
- calc_b  output  8  registered operand B to calculator
- calc_op  output  3  registered opcode to calculator
- calc_load  output  1  one-cycle load enable to calculator operand registers
- calc_y  input  8  calculator result
- calc_c  input  1  calculator carry
- calc_of  input  1  calculator overflow
- rsp_valid  output  1  response held
- rsp_ready  input  1  consumer accepts response
- rsp_y  output  8  captured result
- rsp_c  output  1  captured carry
- rsp_of  output  1  captured overflow
- rsp_op  output  3  opcode echoed from the command
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - calc_a/calc_b/calc_op/rsp_y/rsp_op = 0; calc_load/rsp_valid/rsp_c/rsp_of/busy = 0; counter = 0.
  - Any in-flight command or pending response is discarded, with no partial output.
  - Reset overrides every other input in the same cycle.
- States: IDLE, LOAD, WAIT, RESP. Encoding is free; the only observable behaviour is via ports.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: register cmd_a/b/op into calc_a/b/op and into an internal op copy; go to LOAD.
  - calc_a/b/op otherwise hold their last value.
- LOAD:
  - calc_load=1 for exactly this one cycle; counter loaded with LAT; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter equals 1: capture calc_y/c/of into rsp_y/c/of and copy the op into rsp_op at the clock edge, then go to RESP.
  - The capture edge is the LAT-th edge after the LOAD cycle.
- RESP:
  - rsp_valid=1; rsp_* stable until the rsp_valid&rsp_ready edge, then go to IDLE.
  - rsp_* keep their values after the handshake; only rsp_valid drops.
- Latency and handshakes:
  - If the command handshake is at cycle 0: calc_load is high in cycle 1, and rsp_valid is first high in cycle LAT+2.
  - With rsp_ready tied high, cmd_ready is high again in cycle LAT+3. Maximum throughput is one command per LAT+3 cycles.
  - cmd_ready is combinational from state only; it does not depend on cmd_valid.
  - cmd_ready=0 in LOAD/WAIT/RESP, so a new command can never overlap a pending response. A command held on cmd_* during a busy period is accepted only on return to IDLE.
  - cmd_valid may drop without being accepted; nothing is latched.
  - rsp_ready while rsp_valid=0 is ignored.
- Arithmetic: none. All widths are passed through unchanged.

Optional Feature:
- Macro: CALC_OP_DRIVER_STICKY_OF_EN.
- Defined:
  - Adds input sticky_clr (1) and output sticky_of (1).
  - sticky_of is set at the capture edge when calc_of=1.
  - sticky_of clears on sticky_clr=1; set wins if both happen on the same edge.
  - Reset clears sticky_of to 0.
- Undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- rst=1 for 2 cycles mid-stream -> all outputs 0 after the first reset edge; cmd_ready=1 in the first cycle after rst falls.
- LAT=2, cmd A=0x12 B=0x34 Op=3'b000 accepted at cycle 0, model returns Y=0x46 C=0 Of=0 -> calc_a=0x12/calc_b=0x34 from cycle 1; calc_load=1 only in cycle 1; rsp_valid=1 in cycle 4 with rsp_y=0x46, rsp_op=0.
- rsp_ready=0 for 5 cycles after rsp_valid -> rsp_y/c/of/op stable; cmd_ready=0 and calc_load=0 throughout; with cmd_valid high the whole time, the command is accepted in the cycle after rsp_ready=1.
- rst=1 during WAIT (cycle 2) -> no rsp_valid ever asserted for that command; the next command completes normally with fresh results.
- Back-to-back: 3 commands with cmd_valid and rsp_ready held high, LAT=3 -> accepts at cycles 0, 6, 12; each rsp matches its own operands and opcode.
- With CALC_OP_DRIVER_STICKY_OF_EN: A=0x7F B=0x01, model Of=1 -> rsp_of=1, sticky_of=1. A following op with Of=0 leaves sticky_of=1. sticky_clr pulse -> sticky_of=0 on the next cycle.
